// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data memory arbiter
package dmem_arb_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [2:0]            funct3;
  } mem_req_t;

endpackage

// File: rtl/dmem_req_mux.sv
// rtl/dmem_req_mux.sv - selects the winning request onto the memory port
// With no winner every field and both strobes are driven to zero.
module dmem_req_mux
  import dmem_arb_pkg::*;
(
  input  logic     i_sel_cpu,
  input  logic     i_sel_dbg,
  input  mem_req_t i_cpu,
  input  mem_req_t i_dbg,
  output mem_req_t o_req,
  output logic     o_rd,
  output logic     o_wr
);

  logic w_any;

  assign w_any = i_sel_cpu | i_sel_dbg;

  always_comb begin
    o_req = '0;
    if (i_sel_cpu) begin
      o_req = i_cpu;
    end else if (i_sel_dbg) begin
      o_req = i_dbg;
    end
  end

  assign o_rd = w_any & ~o_req.we;
  assign o_wr = w_any &  o_req.we;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - cpu/dbg arbiter for the single-ported data memory
// Fair-share arbitration with a dbg lock guarded by a watchdog; reads return one cycle later.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int MAX_BURST = 4,
  parameter int LOCK_MAX  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic [2:0]        i_cpu_funct3,
  output logic              o_cpu_gnt,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  input  logic [2:0]        i_dbg_funct3,
  input  logic              i_dbg_lock,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [2:0]        o_mem_funct3,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_locked,
  output logic              o_lock_err
);

  localparam int STREAK_W = $clog2(MAX_BURST + 1);
  localparam int CNT_W    = $clog2(LOCK_MAX);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  logic [STREAK_W-1:0] r_streak;
  logic [CNT_W-1:0]    r_lock_cnt;
  logic                r_lock_err;
  logic                r_cpu_first;
  logic                r_relock_blk;
  logic                r_rd_pend;
  owner_e              r_rd_own;

  logic                w_both;
  logic                w_cpu_win;
  logic                w_dbg_win;
  logic                w_watchdog;
  logic                w_mem_rd;
  logic                w_mem_wr;
  logic                w_cpu_rvalid;
  logic                w_dbg_rvalid;
  mem_req_t            w_cpu_fields;
  mem_req_t            w_dbg_fields;
  mem_req_t            w_mem_req;

  assign w_both = i_cpu_req & i_dbg_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cpu_win    = 1'b0;
    w_dbg_win    = 1'b0;
    w_watchdog   = 1'b0;
    case (r_state)
      ARB: begin
        if (w_both) begin
          // r_cpu_first gives cpu the first contended cycle after a forced release
          if ((r_streak == STREAK_W'(MAX_BURST)) && !r_cpu_first) begin
            w_dbg_win = 1'b1;
          end else begin
            w_cpu_win = 1'b1;
          end
        end else begin
          w_cpu_win = i_cpu_req;
          w_dbg_win = i_dbg_req;
        end
        if (w_dbg_win && i_dbg_lock && !r_relock_blk) begin
          w_state_next = LOCKED;
        end
      end
      LOCKED: begin
        w_dbg_win  = i_dbg_req;
        w_watchdog = (r_lock_cnt == CNT_W'(LOCK_MAX - 1));
        if (!i_dbg_lock || w_watchdog) begin
          w_state_next = ARB;
        end
      end
      default: w_state_next = ARB;
    endcase
    if (reset) begin
      w_cpu_win  = 1'b0;
      w_dbg_win  = 1'b0;
      w_watchdog = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak     <= '0;
      r_lock_cnt   <= '0;
      r_lock_err   <= 1'b0;
      r_cpu_first  <= 1'b0;
      r_relock_blk <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_own     <= OWN_CPU;
    end else begin
      if (w_cpu_win && i_dbg_req) begin
        if (r_streak != STREAK_W'(MAX_BURST)) begin
          r_streak <= r_streak + STREAK_W'(1);
        end
      end else if (w_dbg_win || !i_cpu_req) begin
        r_streak <= '0;
      end

      if ((r_state == LOCKED) && (w_state_next == LOCKED)) begin
        r_lock_cnt <= r_lock_cnt + CNT_W'(1);
      end else begin
        r_lock_cnt <= '0;
      end

      if (w_watchdog) begin
        r_lock_err <= 1'b1;
      end

      if (w_watchdog) begin
        r_cpu_first <= 1'b1;
      end else if ((r_state == ARB) && w_both) begin
        r_cpu_first <= 1'b0;
      end

      // Re-lock stays barred until dbg_lock has been seen low
      if (!i_dbg_lock) begin
        r_relock_blk <= 1'b0;
      end else if (w_watchdog) begin
        r_relock_blk <= 1'b1;
      end

      r_rd_pend <= w_mem_rd;
      r_rd_own  <= w_dbg_win ? OWN_DBG : OWN_CPU;
    end
  end

  assign w_cpu_fields = '{we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata, funct3: i_cpu_funct3};
  assign w_dbg_fields = '{we: i_dbg_we, addr: i_dbg_addr, wdata: i_dbg_wdata, funct3: i_dbg_funct3};

  dmem_req_mux u_req_mux (
    .i_sel_cpu (w_cpu_win),
    .i_sel_dbg (w_dbg_win),
    .i_cpu     (w_cpu_fields),
    .i_dbg     (w_dbg_fields),
    .o_req     (w_mem_req),
    .o_rd      (w_mem_rd),
    .o_wr      (w_mem_wr)
  );

  assign w_cpu_rvalid = ~reset & r_rd_pend & (r_rd_own == OWN_CPU);
  assign w_dbg_rvalid = ~reset & r_rd_pend & (r_rd_own == OWN_DBG);

  assign o_cpu_gnt    = w_cpu_win;
  assign o_cpu_stall  = ~reset & i_cpu_req & ~w_cpu_win;
  assign o_cpu_rvalid = w_cpu_rvalid;
  assign o_cpu_rdata  = w_cpu_rvalid ? i_mem_rdata : '0;
  assign o_dbg_gnt    = w_dbg_win;
  assign o_dbg_rvalid = w_dbg_rvalid;
  assign o_dbg_rdata  = w_dbg_rvalid ? i_mem_rdata : '0;
  assign o_mem_rd     = w_mem_rd;
  assign o_mem_wr     = w_mem_wr;
  assign o_mem_addr   = w_mem_req.addr;
  assign o_mem_wdata  = w_mem_req.wdata;
  assign o_mem_funct3 = w_mem_req.funct3;
  assign o_locked     = ~reset & (r_state == LOCKED);
  assign o_lock_err   = ~reset & r_lock_err;

endmodule
